// File: rtl/flag_word_pipe.sv
// Elastic buffer for packed multi-lane flag words; each word carries a view bit that
// selects native or lane-reversed presentation. Optional accumulator: FLAG_PIPE_STICKY_EN.
module flag_word_pipe #(
  parameter int LANES  = 3,
  parameter int LANE_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*LANE_W-1:0]        in_data,
  input  logic                           in_view,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*LANE_W-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]     out_count
`ifdef FLAG_PIPE_STICKY_EN
  ,
  input  logic                           sticky_clr,
  output logic [LANES*LANE_W-1:0]        sticky_flags
`endif
);

  localparam int W  = LANES * LANE_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid depend only on the registered count, never on the opposite port.
  logic [W:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [W:0]    head;
  logic          head_view;
  logic [W-1:0]  head_data;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_count = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_view, in_data};
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_view = head[W];
  assign head_data = head[W-1:0];

  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (head_view)
        out_data[k*LANE_W +: LANE_W] = head_data[(LANES-1-k)*LANE_W +: LANE_W];
      else
        out_data[k*LANE_W +: LANE_W] = head_data[k*LANE_W +: LANE_W];
    end
  end

`ifdef FLAG_PIPE_STICKY_EN
  logic [W-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)
      sticky_d = '0;
    else if (pop)
      sticky_d = sticky_q | out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_flag_word_pipe.sv
// Directed bench for flag_word_pipe with an expected-word queue fed on every accepted push.
module tb_flag_word_pipe;

  localparam int LANES  = 3;
  localparam int LANE_W = 32;
  localparam int DEPTH  = 2;
  localparam int W      = LANES * LANE_W;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_view;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef FLAG_PIPE_STICKY_EN
  logic          sticky_clr;
  logic [W-1:0]  sticky_flags;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  flag_word_pipe #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_view      (in_view),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count)
`ifdef FLAG_PIPE_STICKY_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] view_model(input logic [W-1:0] d, input logic v);
    logic [W-1:0] r;
    r = d;
    if (v) begin
      for (int k = 0; k < LANES; k++)
        r[k*LANE_W +: LANE_W] = d[(LANES-1-k)*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare on pop, record model result on push (both commit at next posedge)
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          assert (0) else begin
            errors++;
            $error("FAIL unexpected_output observed=%h expected=none", out_data);
          end
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(view_model(in_data, in_view));
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic drive_word(input logic [W-1:0] d, input logic v);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_view  = v;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("push_timeout", W'(0), W'(1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_view  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, W'(exp_q.size()), W'(0));
    check({tag, "_count"}, W'(out_count), W'(0));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
`ifdef FLAG_PIPE_STICKY_EN
    sticky_clr = 1'b0;
`endif
    idle();
    #2;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_count", W'(out_count), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
`ifdef FLAG_PIPE_STICKY_EN
    check("rst_sticky", sticky_flags, W'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset mid-stream
    drive_word(W'(32'h1), 1'b0);
    drive_word(W'(32'h2), 1'b0);
    idle();
    check("midrst_full_count", W'(out_count), W'(2));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_count", W'(out_count), W'(0));
    check("midrst_in_ready",  W'(in_ready),  W'(1));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    drive_word(W'(32'h3), 1'b0);
    idle();
    wait_empty("midrst_drain");

    // native then reversed view, held under backpressure
    out_ready = 1'b0;
    drive_word(96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 1'b0);
    idle();
    check("native_data",  out_data,       96'hAAAAAAAA_BBBBBBBB_CCCCCCCC);
    check("native_count", W'(out_count),  W'(1));
    check("native_valid", W'(out_valid),  W'(1));
    drive_word(96'hAAAAAAAA_BBBBBBBB_CCCCCCCC, 1'b1);
    idle();
    check("mixed_hold_data", out_data,      96'hAAAAAAAA_BBBBBBBB_CCCCCCCC);
    check("mixed_count",     W'(out_count), W'(2));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("reversed_data", out_data, 96'hCCCCCCCC_BBBBBBBB_AAAAAAAA);
    out_ready = 1'b1;
    wait_empty("view_drain");

    // full / backpressure
    out_ready = 1'b0;
    drive_word(W'(32'h11), 1'b0);
    drive_word(W'(32'h22), 1'b0);
    in_valid = 1'b1;
    in_data  = W'(32'h33);
    check("full_count",    W'(out_count), W'(2));
    check("full_in_ready", W'(in_ready),  W'(0));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("full_ignored_count", W'(out_count), W'(2));
    check("full_head",          out_data,      W'(32'h11));
    idle();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after_pop_in_ready", W'(in_ready),  W'(1));
    check("after_pop_count",    W'(out_count), W'(1));
    check("after_pop_head",     out_data,      W'(32'h22));
    wait_empty("full_drain");

    // streaming with pointer wrap, views alternating
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      drive_word(W'(iv), iv[0]);
      check("stream_count", W'(out_count), W'(1));
      check("stream_head",  out_data,      view_model(W'(iv), iv[0]));
    end
    idle();
    wait_empty("stream_drain");

`ifdef FLAG_PIPE_STICKY_EN
    out_ready = 1'b1;
    drive_word(W'(32'h1),   1'b0);
    drive_word(W'(32'h4),   1'b0);
    drive_word(W'(32'h100), 1'b0);
    idle();
    @(posedge clk);
    #1;
    check("sticky_or", sticky_flags, W'(32'h105));
    out_ready = 1'b0;
    drive_word(W'(32'h8), 1'b0);
    idle();
    sticky_clr = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    check("sticky_clr_priority", sticky_flags, W'(0));
    wait_empty("sticky_drain");
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_queue", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_word_pipe.md
# flag_word_pipe

Parametrised, elastic pipeline stage for packed multi-range flag words (LANES × LANE_W bits; default 3 × 32 = 96). It is the registered, flow-controlled successor to the plain flag-word passthrough. It buffers up to DEPTH words behind a valid/ready handshake. On the way out it presents each word either in its native lane order or in the alternate (lane-reversed) union view, selected per word at push time. It sits between any producer and consumer of top-level flag words.

## Interface
Parameters:
- LANES, 3, number of packed ranges (lanes) per flag word; ≥1
- LANE_W, 32, bits per lane; ≥1
- DEPTH, 2, buffer entries; power of two, ≥2

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word
- in_data  in  LANES*LANE_W  flag word; lane k = bits [k*LANE_W +: LANE_W]
- in_view  in  1  0 = native view, 1 = lane-reversed view; captured with the word
- out_valid  out  1  head word available
- out_ready  in  1  consumer accepts head
- out_data  out  LANES*LANE_W  head word after view transform
- out_count  out  $clog2(DEPTH+1)  words currently held
- sticky_clr  in  1  clear sticky accumulator (only with FLAG_PIPE_STICKY_EN)
- sticky_flags  out  LANES*LANE_W  OR of all popped out_data words (only with FLAG_PIPE_STICKY_EN)

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Storage: circular buffer of DEPTH entries, each holding {view, data}. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = (out_count != DEPTH). out_valid = (out_count != 0).
- out_count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- View transform is combinational on the head entry:
  - view 0: out lane k = stored lane k.
  - view 1: out lane k = stored lane LANES-1-k. With LANES=1, view 1 is identical to view 0.
- out_data is don't-care when out_valid=0. The bench checks it only while valid.
- Full with a pop pending: in_ready stays 0 this cycle. There is no same-cycle push-through when full, so no combinational path from out_ready to in_ready.
- Empty: there is no bypass. A word pushed into an empty buffer first appears on the next cycle.
- Once out_valid=1, out_data and out_valid hold until popped (AXI-style stability).
- Reset (any time, including mid-transfer): pointers=0, out_count=0, out_valid=0, in_ready=1, sticky_flags=0. Buffered words are discarded. Storage contents need no reset.

## Timing
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N (one cycle, registered).
- Throughput: one word per cycle sustained whenever out_count<DEPTH or a pop occurs every cycle at DEPTH≥2.
- in_ready and out_valid are pure functions of registered count. out_data is head storage plus lane muxing. No input-to-output combinational paths.
- Reset deassertion is synchronous to clk by the environment. The first push is allowed on the first edge after deassert.

## Configuration
- FLAG_PIPE_STICKY_EN defined:
  - sticky_clr and sticky_flags ports exist.
  - On each pop, sticky_flags <= sticky_flags | out_data (post-transform).
  - sticky_clr=1 sets sticky_flags <= 0 and takes priority over a same-cycle pop OR.
  - Reset value is 0.
- FLAG_PIPE_STICKY_EN undefined: both ports and the accumulator are absent. Datapath behaviour is otherwise identical.

## Test plan
- Reset mid-stream: push 0x1, 0x2 at defaults, assert rst asynchronously between edges -> out_valid=0, out_count=0, in_ready=1 immediately; subsequent push of 0x3 emerges as the first output.
- Native view: push in_data=0xAAAAAAAA_BBBBBBBB_CCCCCCCC, view=0 -> next cycle out_data=0xAAAAAAAA_BBBBBBBB_CCCCCCCC, out_count=1.
- Reversed view: same data, view=1 -> out_data=0xCCCCCCCC_BBBBBBBB_AAAAAAAA. Mixing views per word in consecutive pushes preserves each word's own view.
- Full/backpressure: out_ready=0, push 0x11, 0x22 -> out_count=2, in_ready=0, a third in_valid is ignored. Raise out_ready -> pops yield 0x11 then 0x22, with in_ready=1 from the cycle after the first pop.
- Streaming with wrap: out_ready=1, push 0..9 back-to-back -> outputs 0..9 in order, one per cycle, 1-cycle latency, out_count stays 1, pointers wrap without loss.
- Sticky (macro defined): pop 0x1, 0x4, 0x100 -> sticky_flags=0x105. Assert sticky_clr together with a pop of 0x8 -> sticky_flags=0.
